// File: rtl/ysyx_22050710_mem_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package ysyx_22050710_mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [2:0] MEMOP_NONE  = 3'b111;
  localparam logic [2:0] MEMOP_WORD  = 3'b100;
  localparam logic [2:0] MEMOP_DWORD = 3'b110;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;
endpackage

// File: rtl/ysyx_22050710_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
import ysyx_22050710_mem_pkg::*;

module ysyx_22050710_rr_arb2 (
  input  logic i_if_valid,
  input  logic i_ls_valid,
  input  logic i_last_gnt,
  output logic o_gnt_vld,
  output logic o_gnt_id
);
  always_comb begin
    o_gnt_vld = i_if_valid | i_ls_valid;
    if (i_if_valid && i_ls_valid) o_gnt_id = ~i_last_gnt;
    else if (i_ls_valid)          o_gnt_id = GNT_LS;
    else                          o_gnt_id = GNT_IF;
  end
endmodule

// File: rtl/ysyx_22050710_mem_arbiter.sv
// IFU/LSU arbiter and sequencer for the shared data-memory port: one access in flight,
// held on the port for LATENCY cycles, result returned with rvalid/rready.
import ysyx_22050710_mem_pkg::*;

module ysyx_22050710_mem_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_valid,
  input  logic [63:0] i_if_addr,
  output logic        o_if_ready,
  output logic        o_if_rvalid,
  output logic [63:0] o_if_rdata,
  input  logic        i_if_rready,
  input  logic        i_ls_valid,
  input  logic [63:0] i_ls_addr,
  input  logic [63:0] i_ls_wdata,
  input  logic [2:0]  i_ls_memop,
  input  logic        i_ls_wen,
  output logic        o_ls_ready,
  output logic        o_ls_rvalid,
  output logic [63:0] o_ls_rdata,
  input  logic        i_ls_rready,
  output logic [63:0] o_mem_addr,
  output logic [63:0] o_mem_wdata,
  output logic [2:0]  o_mem_memop,
  output logic        o_mem_wen,
  input  logic [63:0] i_mem_rdata
);
  localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_e        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_last_gnt, r_gnt;
  logic [63:0]   r_addr, r_wdata, r_rdata;
  logic [2:0]    r_memop;
  logic          r_wen;
  logic          w_gnt_vld, w_gnt_id, w_accept, w_last_beat;

  ysyx_22050710_rr_arb2 u_arb (
    .i_if_valid (i_if_valid),
    .i_ls_valid (i_ls_valid),
    .i_last_gnt (r_last_gnt),
    .o_gnt_vld  (w_gnt_vld),
    .o_gnt_id   (w_gnt_id)
  );

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_last_beat = 1'b0;
    o_if_ready  = 1'b0;
    o_ls_ready  = 1'b0;
    o_if_rvalid = 1'b0;
    o_ls_rvalid = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_memop = MEMOP_NONE;
    o_mem_wen   = 1'b0;
    case (r_state)
      IDLE: if (w_gnt_vld && i_rst_n) begin
        w_accept   = 1'b1;
        o_if_ready = (w_gnt_id == GNT_IF);
        o_ls_ready = (w_gnt_id == GNT_LS);
        w_next     = BUSY;
      end
      BUSY: begin
        o_mem_addr  = r_addr;
        o_mem_wdata = r_wdata;
        // reset must silence the port in the very cycle it is asserted
        o_mem_memop = i_rst_n ? r_memop : MEMOP_NONE;
        if (r_cnt == '0) begin
          w_last_beat = 1'b1;
          o_mem_wen   = r_wen & i_rst_n;
          w_next      = RESP;
        end
      end
      RESP: begin
        o_if_rvalid = (r_gnt == GNT_IF);
        o_ls_rvalid = (r_gnt == GNT_LS);
        if ((r_gnt == GNT_IF) ? i_if_rready : i_ls_rready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_last_gnt <= GNT_LS;
      r_gnt      <= GNT_IF;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_memop    <= MEMOP_NONE;
      r_wen      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_gnt      <= w_gnt_id;
        r_last_gnt <= w_gnt_id;
        r_cnt      <= CNT_INIT;
        if (w_gnt_id == GNT_LS) begin
          r_addr  <= i_ls_addr;
          r_wdata <= i_ls_wdata;
          r_memop <= i_ls_memop;
          r_wen   <= i_ls_wen && (i_ls_memop != MEMOP_NONE);
        end else begin
          r_addr  <= i_if_addr;
          r_wdata <= '0;
          r_memop <= MEMOP_WORD;
          r_wen   <= 1'b0;
        end
      end
      if (r_state == BUSY && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_last_beat)
        r_rdata <= (r_wen || r_memop == MEMOP_NONE) ? '0 : i_mem_rdata;
    end
  end

  assign o_if_rdata = r_rdata;
  assign o_ls_rdata = r_rdata;
endmodule

// File: doc/ysyx_22050710_mem_arbiter.md
# ysyx_22050710_mem_arbiter

Two-requester arbiter and sequencer for the shared data-memory port. Instruction fetch (IFU) and load/store unit (LSU) each issue one request at a time with valid/ready. The block grants one round-robin, drives the memory port for a programmable number of cycles, and returns the result with rvalid/rready. It sits between the IFU/LSU and `ysyx_22050710_datamem`, and is the only driver of that port's address, data, MemOP and WrEn inputs.

## Interface
- LATENCY, 1, BUSY cycles per access (≥1); memory read data is sampled in the last one
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_if_valid  in  1  IFU request valid
- i_if_addr  in  64  IFU fetch address
- o_if_ready  out  1  IFU request accepted this cycle
- o_if_rvalid  out  1  IFU response valid
- o_if_rdata  out  64  IFU response data
- i_if_rready  in  1  IFU takes the response
- i_ls_valid  in  1  LSU request valid
- i_ls_addr  in  64  LSU address
- i_ls_wdata  in  64  LSU store data
- i_ls_memop  in  3  LSU MemOP (000–110 access width/sign; 111 = none)
- i_ls_wen  in  1  LSU store when 1, load when 0
- o_ls_ready  out  1  LSU request accepted this cycle
- o_ls_rvalid  out  1  LSU response valid
- o_ls_rdata  out  64  LSU response data (load data; 0 for stores)
- i_ls_rready  in  1  LSU takes the response
- o_mem_addr  out  64  memory address
- o_mem_wdata  out  64  memory write data
- o_mem_memop  out  3  memory MemOP; 3'b111 whenever idle
- o_mem_wen  out  1  memory write enable
- i_mem_rdata  in  64  memory read data (combinational from o_mem_addr)

## Operation
- FSM states:
  - IDLE → BUSY when any valid is high.
  - BUSY → RESP when the counter reaches 0.
  - RESP → IDLE when the granted requester's rready is 1.
- IDLE:
  - Winner's ready is asserted combinationally.
  - Acceptance edge latches addr, wdata, memop, wen and the grant id, and loads the counter with LATENCY-1.
- Arbitration:
  - Single valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - last_grant resets to LSU, so IFU wins the first tie.
- IFU request: memop forced to 3'b100 (32-bit), wen 0, wdata 0.
- BUSY:
  - o_mem_addr, o_mem_memop and o_mem_wdata are driven from the latched request.
  - Counter decrements each cycle.
  - o_mem_wen=1 only in the final BUSY cycle (counter==0) of a store, so exactly one write edge occurs per store.
  - In that final cycle i_mem_rdata is captured into the response register; the capture is 0 for stores.
- RESP:
  - Only the granted requester's rvalid is 1.
  - Data stays stable until rready.
  - Ready outputs are 0 to both requesters.
- Outside BUSY: o_mem_memop=3'b111, o_mem_wen=0, o_mem_addr=0, o_mem_wdata=0.
- A requester may deassert valid before ready with no effect. Once accepted, a request always completes unless reset intervenes.
- LSU memop 3'b111 with valid=1 is still granted. It runs the full LATENCY with no memory access, wen is suppressed, and rdata returns 0.

## Timing
- Request accepted in cycle t (valid & ready). BUSY covers cycles t+1 … t+LATENCY; rvalid first high in t+LATENCY+1.
- rready high in the first RESP cycle → IDLE at t+LATENCY+2. The next acceptance is possible in that cycle, giving a throughput of one access per LATENCY+2 cycles.
- Reset values: state IDLE, counter 0, last_grant LSU, response register 0, all ready/rvalid 0, o_mem_memop 3'b111, o_mem_wen 0, data/addr outputs 0.
- Reset mid-operation:
  - i_rst_n low gates o_mem_wen=0 and o_mem_memop=3'b111 combinationally in that same cycle.
  - The state returns to IDLE at the edge and the pending response is dropped, with no rvalid.
- A simultaneous valid from the other requester during BUSY/RESP is held off (ready 0) and is granted at the next IDLE, per round-robin.

## Structure
- Package `ysyx_22050710_mem_pkg`:
  - State enum: IDLE, BUSY, RESP.
  - MEMOP_NONE=3'b111, MEMOP_WORD=3'b100, MEMOP_DWORD=3'b110.
  - Grant ids GNT_IF=0, GNT_LS=1.
- Sub-module `ysyx_22050710_rr_arb2`: combinational 2-way round-robin grant from the two valids and last_grant.
- The FSM, counter and request/response registers live in the top module.

## Test plan
- IFU alone, LATENCY=1, addr 0x8000_0000, memory word 0x0000_0413:
  - o_if_ready in cycle 0.
  - o_mem_memop=3'b100 in cycle 1.
  - o_if_rvalid with rdata 0x413 in cycle 2.
  - Back in IDLE in cycle 3.
- LSU store, LATENCY=3, addr 0x8000_0100, wdata 0xDEAD_BEEF, memop 3'b100:
  - o_mem_wen high only in cycle 3.
  - o_ls_rvalid in cycle 4 with rdata 0.
  - A subsequent load of the same address returns 0xDEAD_BEEF.
- Both valid every cycle:
  - Grants alternate IF, LS, IF, LS.
  - Never two rvalids in the same cycle.
- Response backpressure: i_ls_rready held 0 for 5 cycles. o_ls_rvalid and rdata stay stable, both readies stay 0, and o_mem_memop stays 3'b111.
- i_rst_n low in the final BUSY cycle of a store:
  - o_mem_wen stays 0 and memory is unchanged.
  - After reset: IDLE, no rvalid, and a new IFU request wins the tie.
- LSU memop 3'b111 with valid: completes after LATENCY, o_mem_wen never 1, rdata 0.
